cond_exec_ctrl: RTL
===================

COND_EXEC_CTRL -- requirements
Module: cond_exec_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 Port clk, input, 1, system clock.
REQ-003 Port rst, input, 1, synchronous active-high reset.
REQ-004 Port id_valid, input, 1, a decoded instruction is present in ID.
REQ-005 Port id_cond, input, 4, condition field of the ID instruction.
REQ-006 Port id_set_flags, input, 1, S bit of the ID instruction.
REQ-007 Port id_is_branch, input, 1, the ID instruction is a branch.
REQ-008 Port ex_busy, input, 1, EX is performing a multi-cycle operation and holds its instruction.
REQ-009 Port alu_status, input, 4, ALU flags {C,V,N,Z} produced by the EX instruction.
REQ-010 Port stall_id, output, 1, combinational; holds IF/ID.
REQ-011 Port ex_en, output, 1, EX instruction passed its condition; gates memory access and writeback.
REQ-012 Port flush, output, 1, registered; kills IF/ID after a taken branch.
REQ-013 Port status_reg, output, 4, architectural flags packed {C,V,N,Z}.

Function
REQ-014 needs_flags SHALL be 1 when id_cond is neither 1110 nor 1111.
REQ-015 pass SHALL be evaluated against status_reg using these conditions.
- EQ: Z. NE: ~Z.
- HS: C. LO: ~C.
- MI: N. PL: ~N.
- VS: V. VC: ~V.
- HI: C&~Z. LS: ~C|Z.
- GE: N==V. LT: N!=V.
- GT: ~Z&(N==V). LE: Z|(N!=V).
- 1110 and 1111: 1.
REQ-016 hazard SHALL equal id_valid & needs_flags & ex_valid & ex_pass & ex_set_flags. There is no flag forwarding.
REQ-017 stall_id SHALL equal (state!=FLUSH) & (hazard | ex_busy).
REQ-018 The FSM SHALL have three states: RUN, HOLD and FLUSH.
- RUN->HOLD when stall_id=1.
- HOLD->RUN when stall_id=0.
- RUN or HOLD -> FLUSH when a taken branch issues: id_valid & id_is_branch & pass & ~stall_id.
- FLUSH->RUN unconditionally after 1 cycle.
REQ-019 flush SHALL be 1 exactly when state==FLUSH. A taken branch SHALL therefore give flush high for exactly one cycle, one cycle after issue.
REQ-020 When ex_busy=0, the EX register SHALL load as follows.
- ex_valid <= id_valid & ~stall_id & (state!=FLUSH).
- ex_pass <= pass.
- ex_set_flags <= id_set_flags.
REQ-021 When ex_busy=1, the EX register and status_reg SHALL hold their values.
REQ-022 ex_en SHALL equal ex_valid & ex_pass.
REQ-023 status_reg SHALL load alu_status at the end of a cycle with ex_valid & ex_pass & ex_set_flags & ~ex_busy. A failed-condition instruction SHALL NOT update flags.
REQ-024 A flag-setting instruction followed by a conditional instruction SHALL produce exactly 1 stall cycle when ex_busy=0, and 1+N stall cycles when ex_busy is high for N cycles.
REQ-025 An ID instruction present during FLUSH SHALL be discarded and SHALL NOT enter EX.
REQ-026 A taken branch coincident with stall_id=1 SHALL NOT issue, and no flush SHALL occur that cycle.
REQ-027 A conditional branch SHALL be evaluated against the flags committed by an immediately preceding flag setter, after the hazard stall.

Reset
REQ-028 While rst=1, the block SHALL set state=RUN, ex_valid=0, ex_pass=0, ex_set_flags=0 and status_reg=0000.
REQ-029 While rst=1, flush, ex_en and stall_id SHALL read 0.
REQ-030 Reset asserted mid-stall or during FLUSH SHALL abort the operation, and the cycle after release SHALL behave as RUN with an empty EX.

Structure
REQ-031 A shared package SHALL hold three items.
- The 4-bit condition-code constants (EQ..AL, 1111).
- The FSM state enum (RUN, HOLD, FLUSH).
- The status bit positions C=3, V=2, N=1, Z=0.
REQ-032 The condition evaluation SHALL be a separate combinational sub-module, cond_eval, with inputs cond[3:0] and status[3:0] and output pass.

Verification
REQ-033 Flag hazard: ADDS producing alu_status=0001, then EQ instruction -> stall_id=1 for 1 cycle, status_reg=0001, EQ instruction gets ex_en=1.
REQ-034 Failed condition: status_reg=0000, NE-... use EQ with S=1 and alu_status=1111 -> ex_en=0 and status_reg stays 0000.
REQ-035 Taken branch: status_reg=1000, BHI with Z=0 -> flush=1 for exactly one cycle and the next ID instruction has ex_en=0; status_reg=1001 with BHI -> no flush.
REQ-036 Multi-cycle: flag setter with ex_busy=1 for 3 cycles, then GT -> 4 stall cycles, status_reg held until ex_busy falls.
REQ-037 Reset: rst pulsed during HOLD -> next cycle stall_id=0, flush=0, ex_en=0, status_reg=0000.
REQ-038 Exhaustive: all 16 id_cond values x 16 status_reg values -> pass matches REQ-015.

Source files
------------

// File: rtl/cond_exec_ctrl_pkg.sv
// cond_exec_ctrl_pkg: condition codes, controller states and status bit positions
package cond_exec_ctrl_pkg;
   localparam logic [3:0] CC_EQ = 4'b0000;
   localparam logic [3:0] CC_NE = 4'b0001;
   localparam logic [3:0] CC_HS = 4'b0010;
   localparam logic [3:0] CC_LO = 4'b0011;
   localparam logic [3:0] CC_MI = 4'b0100;
   localparam logic [3:0] CC_PL = 4'b0101;
   localparam logic [3:0] CC_VS = 4'b0110;
   localparam logic [3:0] CC_VC = 4'b0111;
   localparam logic [3:0] CC_HI = 4'b1000;
   localparam logic [3:0] CC_LS = 4'b1001;
   localparam logic [3:0] CC_GE = 4'b1010;
   localparam logic [3:0] CC_LT = 4'b1011;
   localparam logic [3:0] CC_GT = 4'b1100;
   localparam logic [3:0] CC_LE = 4'b1101;
   localparam logic [3:0] CC_AL = 4'b1110;
   localparam logic [3:0] CC_NV = 4'b1111;
   typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_e;
   localparam int ST_C = 3;
   localparam int ST_V = 2;
   localparam int ST_N = 1;
   localparam int ST_Z = 0;
endpackage

// File: rtl/cond_exec_ctrl_if.sv
// cond_exec_ctrl_if: ID/EX pipeline control bundle between pipeline (master) and controller (slave)
interface cond_exec_ctrl_if;
   logic       id_valid;
   logic [3:0] id_cond;
   logic       id_set_flags;
   logic       id_is_branch;
   logic       ex_busy;
   logic [3:0] alu_status;
   logic       stall_id;
   logic       ex_en;
   logic       flush;
   logic [3:0] status_reg;
   modport master (
      output id_valid, id_cond, id_set_flags, id_is_branch, ex_busy, alu_status,
      input  stall_id, ex_en, flush, status_reg
   );
   modport slave (
      input  id_valid, id_cond, id_set_flags, id_is_branch, ex_busy, alu_status,
      output stall_id, ex_en, flush, status_reg
   );
endinterface

// File: rtl/cond_exec_ctrl_cond_eval.sv
// cond_eval: combinational condition-code test against the {C,V,N,Z} flags
module cond_eval
   import cond_exec_ctrl_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] status,
   output logic       pass
);
   logic c, v, n, z;
   assign c = status[ST_C];
   assign v = status[ST_V];
   assign n = status[ST_N];
   assign z = status[ST_Z];
   // decode each condition code; AL and 1111 always pass
   always_comb begin
      pass = 1'b1;
      case (cond)
         CC_EQ:   pass = z;
         CC_NE:   pass = ~z;
         CC_HS:   pass = c;
         CC_LO:   pass = ~c;
         CC_MI:   pass = n;
         CC_PL:   pass = ~n;
         CC_VS:   pass = v;
         CC_VC:   pass = ~v;
         CC_HI:   pass = c & ~z;
         CC_LS:   pass = ~c | z;
         CC_GE:   pass = n == v;
         CC_LT:   pass = n != v;
         CC_GT:   pass = ~z & (n == v);
         CC_LE:   pass = z | (n != v);
         default: pass = 1'b1;
      endcase
   end
endmodule

// File: rtl/cond_exec_ctrl.sv
// cond_exec_ctrl: conditional-execution, flag-hazard stall and branch-flush controller
module cond_exec_ctrl
   import cond_exec_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   cond_exec_ctrl_if.slave  bus
);
   state_e     state_q, state_d;
   logic       ex_valid_q, ex_valid_d;
   logic       ex_pass_q, ex_pass_d;
   logic       ex_set_flags_q, ex_set_flags_d;
   logic [3:0] status_q, status_d;
   logic       pass, needs_flags, hazard, stall, taken;

   cond_eval u_cond (
      .cond   (bus.id_cond),
      .status (status_q),
      .pass   (pass)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   // EX stage register and architectural flags
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q     <= 1'b0;
         ex_pass_q      <= 1'b0;
         ex_set_flags_q <= 1'b0;
         status_q       <= 4'b0000;
      end else begin
         ex_valid_q     <= ex_valid_d;
         ex_pass_q      <= ex_pass_d;
         ex_set_flags_q <= ex_set_flags_d;
         status_q       <= status_d;
      end
   end

   // hazard detection: no forwarding, so a flag reader waits for a live flag setter in EX
   always_comb begin
      needs_flags = bus.id_cond[3:1] != 3'b111;
      hazard      = bus.id_valid & needs_flags & ex_valid_q & ex_pass_q & ex_set_flags_q;
      stall       = ~rst & (state_q != FLUSH) & (hazard | bus.ex_busy);
      taken       = bus.id_valid & bus.id_is_branch & pass & ~stall;
   end

   // next state: a taken branch wins over hold, FLUSH lasts one cycle
   always_comb begin
      state_d = (state_q == FLUSH) ? RUN : taken ? FLUSH : stall ? HOLD : RUN;
   end

   // EX load and flag commit, both frozen while EX is busy
   always_comb begin
      ex_valid_d     = bus.ex_busy ? ex_valid_q : bus.id_valid & ~stall & (state_q != FLUSH);
      ex_pass_d      = bus.ex_busy ? ex_pass_q : pass;
      ex_set_flags_d = bus.ex_busy ? ex_set_flags_q : bus.id_set_flags;
      status_d       = (ex_valid_q & ex_pass_q & ex_set_flags_q & ~bus.ex_busy) ? bus.alu_status : status_q;
   end

   // outputs, forced quiet while reset is held
   always_comb begin
      bus.stall_id   = stall;
      bus.flush      = ~rst & (state_q == FLUSH);
      bus.ex_en      = ~rst & ex_valid_q & ex_pass_q;
      bus.status_reg = status_q;
   end
endmodule
